// File: rtl/jtpopeye_dmaram.sv
// Object RAM with CPU/DMA bus arbitration.
// The CPU owns the RAM except while the DMA holds the bus grant. A grant is
// given only after the CPU leaves the RAM idle for one cpu_cen tick. A grant
// ends when busrq_n is released or when the grant runs for TIMEOUT ticks.
// After every release, busak_n stays high for GAP ticks.
// Handshake: busrq_n low requests the bus. busak_n low means the DMA may issue
// dma_cs reads; each dma_cs clk in GRANT returns RAM[AD_DMA] on the next clk.
module jtpopeye_dmaram #(
  parameter int AW      = 10,
  parameter int DW      = 8,
  parameter int TIMEOUT = 2048,
  parameter int GAP     = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_cen,
  input  logic          cpu_cs,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_dout,
  output logic [DW-1:0] cpu_din,
  output logic          cpu_stall,
  input  logic          busrq_n,
  output logic          busak_n,
  input  logic          dma_cs,
  input  logic [AW-1:0] AD_DMA,
  output logic [DW-1:0] DD_DMA,
  output logic [AW:0]   dma_cnt,
  output logic          dma_err,
  output logic [1:0]    o_dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_GRANT, S_REL} state_t;

  state_t        r_state, w_next;
  logic [TW-1:0] r_tcnt;
  logic [GW-1:0] r_gcnt;
  logic [AW:0]   r_rcnt;
  logic [AW:0]   r_dma_cnt;
  logic          r_dma_err;
  logic [DW-1:0] r_cpu_din;
  logic [DW-1:0] r_dd;
  logic [DW-1:0] r_mem [0:(2**AW)-1];

  logic w_grant, w_timeout, w_enter_grant, w_leave_grant;

  assign w_grant       = (r_state == S_GRANT);
  assign w_timeout     = (r_tcnt == TW'(TIMEOUT - 1));
  assign w_enter_grant = cpu_cen && (r_state == S_DRAIN) && (w_next == S_GRANT);
  assign w_leave_grant = cpu_cen && w_grant && (w_next == S_REL);

  assign busak_n     = ~w_grant;
  assign cpu_stall   = (r_state == S_DRAIN) || w_grant;
  assign cpu_din     = r_cpu_din;
  assign DD_DMA      = r_dd;
  assign dma_cnt     = r_dma_cnt;
  assign dma_err     = r_dma_err;
  assign o_dbg_state = r_state;

  // Next-state logic; every transition waits for a cpu_cen tick
  always_comb begin
    w_next = r_state;
    if (cpu_cen) begin
      case (r_state)
        S_IDLE:  if (!busrq_n) w_next = S_DRAIN;
        S_DRAIN: begin
          if (busrq_n)      w_next = S_IDLE;
          else if (!cpu_cs) w_next = S_GRANT;
        end
        S_GRANT: if (busrq_n || w_timeout) w_next = S_REL;
        S_REL:   if (r_gcnt == GW'(GAP - 1)) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Grant-length and release-gap counters; each is held at zero outside its state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt <= '0;
      r_gcnt <= '0;
    end else if (cpu_cen) begin
      r_tcnt <= w_grant ? r_tcnt + 1'b1 : '0;
      r_gcnt <= (r_state == S_REL) ? r_gcnt + 1'b1 : '0;
    end
  end

  // Release bookkeeping: snapshot the read count, flag forced releases
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dma_cnt <= '0;
      r_dma_err <= 1'b0;
    end else if (w_leave_grant) begin
      r_dma_cnt <= r_rcnt;
      if (!busrq_n && w_timeout) r_dma_err <= 1'b1;
    end
  end

  // DMA read port; the counter saturates once its top bit (2**AW) is set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rcnt <= '0;
      r_dd   <= '0;
    end else if (w_enter_grant) begin
      r_rcnt <= '0;
    end else if (w_grant && dma_cs) begin
      r_dd <= r_mem[AD_DMA];
      if (!r_rcnt[AW]) r_rcnt <= r_rcnt + 1'b1;
    end
  end

  // CPU read port; holds during GRANT, returns pre-write data on a same-clk write
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_cpu_din <= '0;
    else if (cpu_cs && !w_grant) r_cpu_din <= r_mem[cpu_addr];
  end

  // CPU write port; writes issued during GRANT are dropped
  always_ff @(posedge clk) begin
    if (cpu_cen && cpu_cs && cpu_wr && !w_grant) r_mem[cpu_addr] <= cpu_dout;
  end

endmodule

// File: doc/jtpopeye_dmaram.md
Name: jtpopeye_dmaram

Overview:
- Main-memory responder for the object DMA engine.
- Holds the 1 KB object RAM that the CPU writes sprite tables into.
- Arbitrates the bus between CPU and DMA: answers busrq_n with busak_n once the CPU bus is idle, and stalls the CPU while the grant is held.
- Serves DMA reads (AD_DMA/dma_cs -> DD_DMA) and CPU accesses outside the grant. Sits between the CPU memory map and the video DMA port.

Parameters:
- AW, 10, address width of object RAM (depth 2**AW).
- DW, 8, data width.
- TIMEOUT, 2048, max cpu_cen ticks a grant may last before forced release.
- GAP, 2, cpu_cen ticks busak_n stays high after a release before a new grant.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- cpu_cen  in  1  CPU clock enable; arbitration advances only on it
- cpu_cs  in  1  CPU selects object RAM
- cpu_wr  in  1  CPU write strobe; qualified by cpu_cs and cpu_cen
- cpu_addr  in  AW  CPU address
- cpu_dout  in  DW  CPU write data
- cpu_din  out  DW  CPU read data
- cpu_stall  out  1  high while CPU must be held (drives CPU wait/cen gating)
- busrq_n  in  1  DMA bus request, active-low
- busak_n  out  1  bus acknowledge, active-low
- dma_cs  in  1  DMA read strobe
- AD_DMA  in  AW  DMA read address
- DD_DMA  out  DW  DMA read data
- dma_cnt  out  AW+1  number of DMA reads served in last completed grant
- dma_err  out  1  sticky: a grant was force-released by timeout

Behaviour:
- Reset values: busak_n=1, cpu_stall=0, cpu_din=0, DD_DMA=0, dma_cnt=0, dma_err=0, state=IDLE, all counters 0. RAM contents are not reset.
- State machine (transitions only on cpu_cen except where noted):
  - IDLE: busrq_n=0 -> DRAIN; cpu_stall rises the same tick.
  - DRAIN: CPU access in flight is allowed to finish. With cpu_cs=0 on a tick -> GRANT and busak_n=0. With cpu_cs=1 -> stay.
  - GRANT: busak_n=0, cpu_stall=1. busrq_n=1 -> REL. Grant tick counter reaching TIMEOUT-1 -> REL and dma_err=1.
  - REL: busak_n=1, cpu_stall=0. Latch dma_cnt from the read counter. After GAP ticks -> IDLE. busrq_n is ignored during REL.
- busrq_n released during DRAIN: return to IDLE, no grant, cpu_stall drops; dma_cnt is unchanged.
- DMA read port:
  - Active only in GRANT. dma_cs=1 on any clk (not gated by cpu_cen) -> DD_DMA=RAM[AD_DMA] on the next clk edge. Read counter +1, saturating at 2**AW.
  - dma_cs outside GRANT: DD_DMA holds its value and nothing is counted.
  - The read counter clears on entry to GRANT.
- CPU port:
  - Read latency 1 clk: cpu_din=RAM[cpu_addr] registered when cpu_cs=1.
  - Write takes effect on a cpu_cen tick with cpu_cs & cpu_wr.
  - While state is GRANT, CPU writes are dropped and cpu_din holds.
  - Write to an address on the same clk as a CPU read of that address: cpu_din returns the old data (read-before-write).
- Address wrap: addresses are exactly AW bits; there is no out-of-range case.
- The timeout counter counts cpu_cen ticks in GRANT only and clears on GRANT entry.
- dma_err clears only on rst.
- Reset mid-grant: busak_n returns to 1 and cpu_stall to 0 asynchronously. RAM is untouched.

Test Plan:
- CPU writes 0x3C to 0x012 and 0xA5 to 0x3FF, then reads both -> cpu_din 0x3C and 0xA5 one clk after each read. busak_n stays 1 throughout.
- With cpu_cs low, pull busrq_n low -> busak_n=0 two cpu_cen ticks later (IDLE->DRAIN->GRANT). Issue dma_cs at 0x012 -> DD_DMA=0x3C next clk.
- busrq_n low while cpu_cs held high for 3 ticks -> busak_n stays 1 until the first tick with cpu_cs=0, then falls. cpu_stall is high from the first tick.
- In GRANT, issue 40 dma_cs reads, then release busrq_n -> busak_n=1 on the next tick and dma_cnt=40. Re-request immediately -> no grant until GAP=2 ticks have elapsed.
- Hold busrq_n low with TIMEOUT=16 -> busak_n rises after 16 GRANT ticks and dma_err=1. dma_err stays 1 after busrq_n releases.
- In GRANT, CPU writes 0x77 to 0x012 -> the write is dropped, and a later read of 0x012 returns 0x3C. Asserting rst mid-grant -> busak_n=1 and cpu_stall=0 immediately.
